mod_mul: RTL

Sequential 256-bit modular multiplier over the secp256k1 field prime p. It is the forward counterpart of the modular inverter: it computes product = a·b mod p, and it is the block that checks an inverse, since x·inv(x) mod p = 1. It uses MSB-first interleaved double-and-add with one operand bit per cycle. It sits beside `mod_inv` under the point-arithmetic controller and uses the same start/done handshake.

---
 rtl/secp256k1_pkg.sv | 21 ++
 rtl/mod_mul_if.sv | 12 +
 rtl/mod_mul_add.sv | 17 +
 rtl/mod_mul.sv | 82 ++++++++
 4 files changed

// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field constants and the mod_mul sequencer state type.
package secp256k1_pkg;

  localparam logic [255:0] P_SECP256K1 =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    MM_IDLE = 2'd0,
    MM_RUN  = 2'd1,
    MM_DONE = 2'd2
  } mm_state_e;

  // Single conditional subtract; caller guarantees x < 2p.
  function automatic logic [255:0] reduce_once(input logic [256:0] x,
                                               input logic [255:0] p);
    logic [256:0] diff;
    diff = x - {1'b0, p};
    return (x >= {1'b0, p}) ? diff[255:0] : x[255:0];
  endfunction

endpackage

// File: rtl/mod_mul_if.sv
// Start/done handshake and operand/result bus between the point controller and mod_mul.
interface mod_mul_if;
  logic         start;
  logic [255:0] a;
  logic [255:0] b;
  logic [255:0] product;
  logic         busy;
  logic         done;

  modport master (output start, a, b, input product, busy, done);
  modport slave  (input start, a, b, output product, busy, done);
endinterface

// File: rtl/mod_mul_add.sv
// Combinational (x + y) mod p for x, y < p: 257-bit sum and one conditional subtract.
module mod_mul_add
  import secp256k1_pkg::*;
#(
  parameter logic [255:0] P = P_SECP256K1
) (
  input  logic [255:0] x_i,
  input  logic [255:0] y_i,
  output logic [255:0] sum_o
);

  logic [256:0] sum;

  assign sum   = {1'b0, x_i} + {1'b0, y_i};
  assign sum_o = reduce_once(sum, P);

endmodule

// File: rtl/mod_mul.sv
// secp256k1 modular multiplier: MSB-first interleaved double-and-add, one bit of b per cycle.
module mod_mul
  import secp256k1_pkg::*;
#(
  parameter logic [255:0] P = P_SECP256K1
) (
  input  logic       clk,
  input  logic       reset,
  mod_mul_if.slave   bus
);

  mm_state_e    state_q, state_d;
  logic [255:0] a_q, a_d;
  logic [255:0] b_q, b_d;
  logic [255:0] acc_q, acc_d;
  logic [7:0]   idx_q, idx_d;
  logic [255:0] product_q, product_d;

  logic [255:0] dbl;
  logic [255:0] dbl_add;
  logic [255:0] step;

  mod_mul_add #(.P(P)) u_dbl (.x_i(acc_q), .y_i(acc_q), .sum_o(dbl));
  mod_mul_add #(.P(P)) u_add (.x_i(dbl),   .y_i(a_q),   .sum_o(dbl_add));

  assign step = b_q[idx_q] ? dbl_add : dbl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= MM_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      idx_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    product_d = product_q;
    case (state_q)
      MM_IDLE, MM_DONE: begin
        state_d = MM_IDLE;
        if (bus.start) begin
          // a < 2^256 < 2p, so one subtract brings it below p
          a_d     = reduce_once({1'b0, bus.a}, P);
          b_d     = bus.b;
          acc_d   = '0;
          idx_d   = 8'd255;
          state_d = MM_RUN;
        end
      end
      MM_RUN: begin
        acc_d = step;
        if (idx_q == 8'd0) begin
          product_d = step;
          state_d   = MM_DONE;
        end else begin
          idx_d = idx_q - 8'd1;
        end
      end
      default: state_d = MM_IDLE;
    endcase
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q == MM_RUN);
  assign bus.done    = (state_q == MM_DONE);

endmodule
